// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle MIPS-subset control unit: FSM states,
// opcode/funct values, datapath select codes and exception causes.
package ctrl_pkg;

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_EXEC   = 4'd2;
  localparam logic [3:0] S_MEM    = 4'd3;
  localparam logic [3:0] S_WB     = 4'd4;
  localparam logic [3:0] S_MULDIV = 4'd5;
  localparam logic [3:0] S_EXC    = 4'd6;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_RTE   = 6'h10;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_JR    = 6'h08;
  localparam logic [5:0] F_BREAK = 6'h0D;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_ERET  = 6'h18;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_SLT   = 6'h2A;

  localparam logic [2:0] ALU_PASSA = 3'd0;
  localparam logic [2:0] ALU_ADD   = 3'd1;
  localparam logic [2:0] ALU_SUB   = 3'd2;
  localparam logic [2:0] ALU_AND   = 3'd3;
  localparam logic [2:0] ALU_OR    = 3'd4;
  localparam logic [2:0] ALU_SLT   = 3'd7;

  localparam logic [2:0] PCS_ALU    = 3'd0;
  localparam logic [2:0] PCS_ALUOUT = 3'd1;
  localparam logic [2:0] PCS_JUMP   = 3'd2;
  localparam logic [2:0] PCS_EPC    = 3'd3;
  localparam logic [2:0] PCS_VEC    = 3'd4;

  localparam logic [2:0] M2R_ALUOUT = 3'd0;
  localparam logic [2:0] M2R_MDR    = 3'd1;
  localparam logic [2:0] M2R_HI     = 3'd2;
  localparam logic [2:0] M2R_LO     = 3'd3;
  localparam logic [2:0] M2R_PC     = 3'd4;

  localparam logic [1:0] RD_RT = 2'd0;
  localparam logic [1:0] RD_RD = 2'd1;
  localparam logic [1:0] RD_RA = 2'd2;

  localparam logic [2:0] SRCB_B      = 3'd0;
  localparam logic [2:0] SRCB_FOUR   = 3'd1;
  localparam logic [2:0] SRCB_IMM    = 3'd2;
  localparam logic [2:0] SRCB_BRANCH = 3'd3;

  localparam logic [1:0] EXC_ILLEGAL = 2'd0;
  localparam logic [1:0] EXC_OVF     = 2'd1;
  localparam logic [1:0] EXC_DIV0    = 2'd2;

  typedef enum logic [3:0] {
    C_NOP, C_RALU, C_ADDI, C_LW, C_SW, C_BEQ, C_BNE, C_J,
    C_JAL, C_JR, C_RTE, C_BRK, C_MULT, C_DIV, C_MFHI, C_MFLO
  } insn_class_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_wr;
    logic       ir_write;
    logic       reg_write;
    logic       epc_write;
    logic       alu_src_a;
    logic       muldiv_start;
    logic       hilo_write;
    logic [1:0] reg_dest;
    logic [2:0] mem_to_reg;
    logic [2:0] alu_src_b;
    logic [2:0] alu_op;
    logic [2:0] pc_source;
  } ctrl_out_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Instruction-field/flag inputs and datapath control outputs of the multicycle
// controller; master = controller, slave = datapath.
interface multicycle_ctrl_if;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        overflow;
  logic        divby0;
  logic        zero;
  logic        pc_write;
  logic        pc_write_cond;
  logic        iord;
  logic        mem_wr;
  logic        ir_write;
  logic        reg_write;
  logic        epc_write;
  logic        alu_src_a;
  logic        muldiv_start;
  logic        hilo_write;
  logic [1:0]  reg_dest;
  logic [2:0]  mem_to_reg;
  logic [2:0]  alu_src_b;
  logic [2:0]  alu_op;
  logic [2:0]  pc_source;
  logic [1:0]  exc_cause;
  logic [31:0] exc_vec_addr;
  logic [3:0]  state;

  modport master (
    input  opcode, funct, overflow, divby0, zero,
    output pc_write, pc_write_cond, iord, mem_wr, ir_write, reg_write,
           epc_write, alu_src_a, muldiv_start, hilo_write, reg_dest,
           mem_to_reg, alu_src_b, alu_op, pc_source, exc_cause,
           exc_vec_addr, state
  );

  modport slave (
    output opcode, funct, overflow, divby0, zero,
    input  pc_write, pc_write_cond, iord, mem_wr, ir_write, reg_write,
           epc_write, alu_src_a, muldiv_start, hilo_write, reg_dest,
           mem_to_reg, alu_src_b, alu_op, pc_source, exc_cause,
           exc_vec_addr, state
  );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational opcode/funct classifier; the result is only consumed while the
// controller sits in DECODE.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  output insn_class_t cls,
  output logic [2:0]  alu_fn,
  output logic        ovf_chk,
  output logic        illegal
);

  always_comb begin
    cls     = C_NOP;
    alu_fn  = ALU_ADD;
    ovf_chk = 1'b0;
    illegal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          F_ADD:   begin cls = C_RALU; alu_fn = ALU_ADD; ovf_chk = 1'b1; end
          F_SUB:   begin cls = C_RALU; alu_fn = ALU_SUB; ovf_chk = 1'b1; end
          F_AND:   begin cls = C_RALU; alu_fn = ALU_AND; end
          F_OR:    begin cls = C_RALU; alu_fn = ALU_OR;  end
          F_SLT:   begin cls = C_RALU; alu_fn = ALU_SLT; end
          F_JR:    cls = C_JR;
          F_BREAK: cls = C_BRK;
          F_MFHI:  cls = C_MFHI;
          F_MFLO:  cls = C_MFLO;
          F_MULT:  cls = C_MULT;
          F_DIV:   cls = C_DIV;
          default: illegal = 1'b1;
        endcase
      end
      OP_ADDI: begin cls = C_ADDI; ovf_chk = 1'b1; end
      OP_LW:   cls = C_LW;
      OP_SW:   cls = C_SW;
      OP_BEQ:  cls = C_BEQ;
      OP_BNE:  cls = C_BNE;
      OP_J:    cls = C_J;
      OP_JAL:  cls = C_JAL;
      OP_RTE: begin
        if (funct == F_ERET) cls = C_RTE;
        else                 illegal = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle FSM controller for the MIPS-subset datapath. Define
// CTRL_EXCEPTION_EN to enable the EXC state, exc_cause and epc_write.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int          MEM_LAT       = 1,
  parameter int          MULDIV_CYCLES = 32,
  parameter logic [31:0] EXC_VEC_BASE  = 32'h0000_00FD
) (
  input  logic              clk,
  input  logic              reset_n,
  multicycle_ctrl_if.master bus
);

`ifdef CTRL_EXCEPTION_EN
  localparam bit EXC_EN = 1'b1;
`else
  localparam bit EXC_EN = 1'b0;
`endif

  localparam logic [2:0] WAIT_TERM  = 3'(MEM_LAT - 1);
  localparam logic [5:0] MD_TERM    = 6'(MULDIV_CYCLES);
  localparam logic [5:0] EXC_TERM   = 6'(MEM_LAT + 1);

  logic [3:0]  state, nxt_state;
  logic [2:0]  wait_cnt;
  logic [5:0]  cyc_cnt, cyc_term;
  logic        wait_last;
  insn_class_t cls_q, dec_cls;
  logic [2:0]  alu_fn_q, dec_alu_fn;
  logic        ovf_chk_q, dec_ovf_chk, dec_illegal;
  logic        exc_take;
  logic [1:0]  exc_code, exc_cause_q;
  ctrl_out_t   co, ctl;

  ctrl_decode u_decode (
    .opcode  (bus.opcode),
    .funct   (bus.funct),
    .cls     (dec_cls),
    .alu_fn  (dec_alu_fn),
    .ovf_chk (dec_ovf_chk),
    .illegal (dec_illegal)
  );

  assign wait_last = (wait_cnt == WAIT_TERM);
  assign cyc_term  = (state == S_EXC) ? EXC_TERM : MD_TERM;

  // divby0 becomes valid once the divider has seen muldiv_start, i.e. at cyc_cnt==1
  always_comb begin
    nxt_state = state;
    exc_take  = 1'b0;
    exc_code  = EXC_ILLEGAL;
    case (state)
      S_FETCH: if (wait_last) nxt_state = S_DECODE;
      S_DECODE: begin
        if (dec_illegal) begin
          nxt_state = S_FETCH;
          exc_take  = EXC_EN;
          exc_code  = EXC_ILLEGAL;
        end else begin
          case (dec_cls)
            C_MULT, C_DIV: nxt_state = S_MULDIV;
            C_MFHI, C_MFLO: nxt_state = S_WB;
            C_NOP:          nxt_state = S_FETCH;
            default:        nxt_state = S_EXEC;
          endcase
        end
      end
      S_EXEC: begin
        case (cls_q)
          C_RALU, C_ADDI: begin
            nxt_state = S_WB;
            if (ovf_chk_q && bus.overflow) begin
              exc_take = EXC_EN;
              exc_code = EXC_OVF;
            end
          end
          C_LW, C_SW: nxt_state = S_MEM;
          default:    nxt_state = S_FETCH;
        endcase
      end
      S_MEM: if (wait_last) nxt_state = (cls_q == C_LW) ? S_WB : S_FETCH;
      S_WB:  nxt_state = S_FETCH;
      S_MULDIV: begin
        if (cls_q == C_DIV && cyc_cnt == 6'd1 && bus.divby0) begin
          exc_take = EXC_EN;
          exc_code = EXC_DIV0;
        end else if (cyc_cnt == MD_TERM) begin
          nxt_state = S_FETCH;
        end
      end
      S_EXC:   if (cyc_cnt == EXC_TERM) nxt_state = S_FETCH;
      default: nxt_state = S_FETCH;
    endcase
    if (exc_take) nxt_state = S_EXC;
  end

  // both counters restart on every state change and hold at their terminal value
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_FETCH;
      wait_cnt  <= 3'd0;
      cyc_cnt   <= 6'd0;
      cls_q     <= C_NOP;
      alu_fn_q  <= ALU_ADD;
      ovf_chk_q <= 1'b0;
    end else begin
      state <= nxt_state;
      if (nxt_state != state) begin
        wait_cnt <= 3'd0;
        cyc_cnt  <= 6'd0;
      end else begin
        if (!wait_last)          wait_cnt <= wait_cnt + 3'd1;
        if (cyc_cnt != cyc_term) cyc_cnt  <= cyc_cnt + 6'd1;
      end
      if (state == S_DECODE) begin
        cls_q     <= dec_cls;
        alu_fn_q  <= dec_alu_fn;
        ovf_chk_q <= dec_ovf_chk;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      exc_cause_q <= EXC_ILLEGAL;
    else if (exc_take) exc_cause_q <= exc_code;
  end

  // Branches resolve zero here: pc_write carries the taken decision for beq and
  // bne alike, while pc_write_cond only marks the conditional-branch cycle.
  always_comb begin
    co = '0;
    case (state)
      S_FETCH: begin
        if (wait_last) begin
          co.ir_write  = 1'b1;
          co.pc_write  = 1'b1;
          co.alu_src_b = SRCB_FOUR;
          co.alu_op    = ALU_ADD;
        end
      end
      S_DECODE: begin
        co.alu_src_b = SRCB_BRANCH;
        co.alu_op    = ALU_ADD;
      end
      S_EXEC: begin
        case (cls_q)
          C_RALU: begin
            co.alu_src_a = 1'b1;
            co.alu_op    = alu_fn_q;
          end
          C_ADDI, C_LW, C_SW: begin
            co.alu_src_a = 1'b1;
            co.alu_src_b = SRCB_IMM;
            co.alu_op    = ALU_ADD;
          end
          C_BEQ, C_BNE: begin
            co.alu_src_a     = 1'b1;
            co.alu_op        = ALU_SUB;
            co.pc_source     = PCS_ALUOUT;
            co.pc_write_cond = 1'b1;
            co.pc_write      = bus.zero ^ (cls_q == C_BNE);
          end
          C_J: begin
            co.pc_source = PCS_JUMP;
            co.pc_write  = 1'b1;
          end
          C_JAL: begin
            co.pc_source  = PCS_JUMP;
            co.pc_write   = 1'b1;
            co.reg_write  = 1'b1;
            co.reg_dest   = RD_RA;
            co.mem_to_reg = M2R_PC;
          end
          C_JR: begin
            co.alu_src_a = 1'b1;
            co.alu_op    = ALU_PASSA;
            co.pc_source = PCS_ALU;
            co.pc_write  = 1'b1;
          end
          C_RTE: begin
            co.pc_source = PCS_EPC;
            co.pc_write  = 1'b1;
          end
          C_BRK: begin
            co.alu_src_b = SRCB_FOUR;
            co.alu_op    = ALU_SUB;
            co.pc_source = PCS_ALU;
            co.pc_write  = 1'b1;
          end
          default: co = '0;
        endcase
      end
      S_MEM: begin
        co.iord   = 1'b1;
        co.mem_wr = (cls_q == C_SW);
      end
      S_WB: begin
        co.reg_write = 1'b1;
        case (cls_q)
          C_RALU:  co.reg_dest = RD_RD;
          C_LW:    co.mem_to_reg = M2R_MDR;
          C_MFHI:  begin co.reg_dest = RD_RD; co.mem_to_reg = M2R_HI; end
          C_MFLO:  begin co.reg_dest = RD_RD; co.mem_to_reg = M2R_LO; end
          default: co.reg_dest = RD_RT;
        endcase
      end
      S_MULDIV: begin
        if (cyc_cnt < MD_TERM) co.muldiv_start = 1'b1;
        else                   co.hilo_write   = 1'b1;
      end
      S_EXC: begin
        if (cyc_cnt == 6'd0) begin
          co.epc_write = 1'b1;
          co.alu_src_b = SRCB_FOUR;
          co.alu_op    = ALU_SUB;
        end else if (cyc_cnt < EXC_TERM) begin
          co.iord = 1'b1;
        end else begin
          co.pc_source = PCS_VEC;
          co.pc_write  = 1'b1;
        end
      end
      default: co = '0;
    endcase
  end

  assign ctl = reset_n ? co : '0;

  assign bus.pc_write      = ctl.pc_write;
  assign bus.pc_write_cond = ctl.pc_write_cond;
  assign bus.iord          = ctl.iord;
  assign bus.mem_wr        = ctl.mem_wr;
  assign bus.ir_write      = ctl.ir_write;
  assign bus.reg_write     = ctl.reg_write;
  assign bus.epc_write     = ctl.epc_write;
  assign bus.alu_src_a     = ctl.alu_src_a;
  assign bus.muldiv_start  = ctl.muldiv_start;
  assign bus.hilo_write    = ctl.hilo_write;
  assign bus.reg_dest      = ctl.reg_dest;
  assign bus.mem_to_reg    = ctl.mem_to_reg;
  assign bus.alu_src_b     = ctl.alu_src_b;
  assign bus.alu_op        = ctl.alu_op;
  assign bus.pc_source     = ctl.pc_source;
  assign bus.exc_cause     = reset_n ? exc_cause_q : 2'd0;
  assign bus.exc_vec_addr  = reset_n ? (EXC_VEC_BASE + 32'(exc_cause_q)) : 32'd0;
  assign bus.state         = reset_n ? state : S_FETCH;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed testbench for multicycle_ctrl (MEM_LAT=3, MULDIV_CYCLES=32); the
// exception checks follow whether CTRL_EXCEPTION_EN is defined for the build.
module tb_multicycle_ctrl;
  import ctrl_pkg::*;

  localparam int M = 3;
  localparam int K = 32;
  localparam int VEC_BASE = 32'h0000_00FD;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   testsRun = 0;
  int   testsFailed = 0;

  int cycles, nIrw, firstIrw, nRegw, regwCycle, nIord, nMemwr, nMds, firstMds;
  int nHilo, hiloCycle, nPcw, nPcwc, nEpc, nExc;
  logic [31:0] rwDest, rwM2r, lastPcs, pcwcSrc, seenCause, seenVec;

  multicycle_ctrl_if bus();

  multicycle_ctrl #(.MEM_LAT(M), .MULDIV_CYCLES(K), .EXC_VEC_BASE(32'h0000_00FD)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn,
                               input logic z, input logic ovf, input logic d0);
    bus.opcode   = op;
    bus.funct    = fn;
    bus.zero     = z;
    bus.overflow = ovf;
    bus.divby0   = d0;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic recordCycle(input int c);
    if (bus.ir_write) begin nIrw++; if (firstIrw == 0) firstIrw = c; end
    if (bus.reg_write) begin
      nRegw++; regwCycle = c;
      rwDest = 32'(bus.reg_dest); rwM2r = 32'(bus.mem_to_reg);
    end
    if (bus.iord) begin
      nIord++;
      if (bus.state == S_EXC) seenVec = bus.exc_vec_addr;
    end
    if (bus.mem_wr) nMemwr++;
    if (bus.muldiv_start) begin nMds++; if (firstMds == 0) firstMds = c; end
    if (bus.hilo_write) begin nHilo++; hiloCycle = c; end
    if (bus.pc_write) begin nPcw++; lastPcs = 32'(bus.pc_source); end
    if (bus.pc_write_cond) begin nPcwc++; pcwcSrc = 32'(bus.pc_source); end
    if (bus.epc_write) begin nEpc++; seenCause = 32'(bus.exc_cause); end
    if (bus.state == S_EXC) nExc++;
  endtask

  // Runs one instruction from its first FETCH cycle until FETCH is re-entered.
  task automatic runInsn(input logic [5:0] op, input logic [5:0] fn,
                         input logic z, input logic ovf, input logic d0);
    bit left = 1'b0;
    applyStimulus(op, fn, z, ovf, d0);
    cycles = -1; nIrw = 0; firstIrw = 0; nRegw = 0; regwCycle = 0; nIord = 0;
    nMemwr = 0; nMds = 0; firstMds = 0; nHilo = 0; hiloCycle = 0; nPcw = 0;
    nPcwc = 0; nEpc = 0; nExc = 0; rwDest = '1; rwM2r = '1; lastPcs = '1;
    pcwcSrc = '1; seenCause = '1; seenVec = '1;
    for (int c = 1; c <= 200; c++) begin
      if (bus.state != S_FETCH) left = 1'b1;
      else if (left) begin cycles = c - 1; break; end
      recordCycle(c);
      nextCycle();
    end
  endtask

  initial begin
    applyStimulus(6'h00, 6'h00, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_outs", 32'({bus.pc_write, bus.pc_write_cond, bus.iord, bus.mem_wr,
                bus.ir_write, bus.reg_write, bus.epc_write, bus.alu_src_a, bus.muldiv_start,
                bus.hilo_write, bus.reg_dest, bus.mem_to_reg, bus.alu_src_b, bus.alu_op,
                bus.pc_source, bus.exc_cause}), 32'd0);
    checkOutput("rst_state", 32'(bus.state), 32'(S_FETCH));
    reset_n = 1'b1;
    #1;

    runInsn(OP_RTYPE, F_ADD, 1'b0, 1'b0, 1'b0);
    checkOutput("add_lat", cycles, M + 3);
    checkOutput("add_irw_cyc", firstIrw, M);
    checkOutput("add_irw_n", nIrw, 1);
    checkOutput("add_regw_cyc", regwCycle, M + 3);
    checkOutput("add_rdst", rwDest, 1);
    checkOutput("add_m2r", rwM2r, 0);

    runInsn(OP_LW, 6'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("lw_lat", cycles, 2 * M + 3);
    checkOutput("lw_regw_cyc", regwCycle, 9);
    checkOutput("lw_m2r", rwM2r, 1);
    checkOutput("lw_rdst", rwDest, 0);
    checkOutput("lw_iord_n", nIord, M);
    checkOutput("lw_memwr_n", nMemwr, 0);

    runInsn(OP_SW, 6'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("sw_lat", cycles, 2 * M + 2);
    checkOutput("sw_memwr_n", nMemwr, M);
    checkOutput("sw_regw_n", nRegw, 0);

    runInsn(OP_BEQ, 6'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("beq1_lat", cycles, M + 2);
    checkOutput("beq1_pcwc", nPcwc, 1);
    checkOutput("beq1_src", pcwcSrc, 1);
    checkOutput("beq1_pcw_n", nPcw, 2);
    runInsn(OP_BEQ, 6'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("beq0_pcwc", nPcwc, 1);
    checkOutput("beq0_src", pcwcSrc, 1);
    checkOutput("beq0_pcw_n", nPcw, 1);
    runInsn(OP_BNE, 6'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("bne1_pcw_n", nPcw, 1);
    runInsn(OP_BNE, 6'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("bne0_pcw_n", nPcw, 2);

    runInsn(OP_JAL, 6'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("jal_lat", cycles, M + 2);
    checkOutput("jal_rdst", rwDest, 2);
    checkOutput("jal_m2r", rwM2r, 4);
    checkOutput("jal_pcs", lastPcs, 2);

    runInsn(OP_RTYPE, F_MFHI, 1'b0, 1'b0, 1'b0);
    checkOutput("mfhi_lat", cycles, M + 2);
    checkOutput("mfhi_m2r", rwM2r, 2);

    runInsn(OP_RTYPE, F_MULT, 1'b0, 1'b0, 1'b0);
    checkOutput("mult_lat", cycles, M + K + 2);
    checkOutput("mult_mds_n", nMds, K);
    checkOutput("mult_mds_first", firstMds, M + 2);
    checkOutput("mult_hilo_n", nHilo, 1);
    checkOutput("mult_hilo_cyc", hiloCycle, M + K + 2);

    runInsn(OP_RTYPE, F_DIV, 1'b0, 1'b0, 1'b1);
`ifdef CTRL_EXCEPTION_EN
    checkOutput("div0_lat", cycles, 2 * M + 5);
    checkOutput("div0_hilo_n", nHilo, 0);
    checkOutput("div0_epc_n", nEpc, 1);
    checkOutput("div0_cause", seenCause, 2);
    checkOutput("div0_vec", seenVec, VEC_BASE + 2);
    checkOutput("div0_pcs", lastPcs, 4);
`else
    checkOutput("div0_lat", cycles, M + K + 2);
    checkOutput("div0_hilo_n", nHilo, 1);
    checkOutput("div0_epc_n", nEpc, 0);
`endif

    runInsn(OP_ADDI, 6'h00, 1'b0, 1'b1, 1'b0);
`ifdef CTRL_EXCEPTION_EN
    checkOutput("ovf_lat", cycles, 2 * M + 4);
    checkOutput("ovf_regw_n", nRegw, 0);
    checkOutput("ovf_cause", seenCause, 1);
`else
    checkOutput("ovf_lat", cycles, M + 3);
    checkOutput("ovf_regw_n", nRegw, 1);
    checkOutput("ovf_rdst", rwDest, 0);
`endif

    runInsn(6'h3F, 6'h00, 1'b0, 1'b0, 1'b0);
`ifdef CTRL_EXCEPTION_EN
    checkOutput("ill_lat", cycles, 2 * M + 3);
    checkOutput("ill_exc_cycles", nExc, M + 2);
    checkOutput("ill_cause", seenCause, 0);
    checkOutput("ill_vec", seenVec, VEC_BASE);
`else
    checkOutput("ill_lat", cycles, M + 1);
    checkOutput("ill_pcw_n", nPcw, 1);
    checkOutput("ill_regw_n", nRegw, 0);
    checkOutput("ill_iord_n", nIord, 0);
    checkOutput("ill_epc_n", nEpc, 0);
`endif

    applyStimulus(OP_RTYPE, F_MULT, 1'b0, 1'b0, 1'b0);
    repeat (M + 5) nextCycle();
    checkOutput("mid_state", 32'(bus.state), 32'(S_MULDIV));
    checkOutput("mid_mds", 32'(bus.muldiv_start), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("arst_mds", 32'(bus.muldiv_start), 32'd0);
    checkOutput("arst_state", 32'(bus.state), 32'(S_FETCH));
    checkOutput("arst_wr", 32'({bus.reg_write, bus.hilo_write, bus.mem_wr, bus.pc_write,
                bus.ir_write, bus.epc_write}), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
